id_hazard_ctrl: RTL and testbench



---
 rtl/core_pkg.sv | 36 +++
 rtl/hazard_scoreboard.sv | 57 +++++
 rtl/id_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_id_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode constants, register index type and opcode class decode
package core_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic known;
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } op_class_t;

    typedef enum logic {ST_RUN, ST_STALL} hz_state_t;

    // Unknown opcodes decode to all-zero: no sources, no write, not issuable.
    function automatic op_class_t op_class(input logic [6:0] opcode);
        op_class_t c;
        c = '0;
        case (opcode)
            OP_R:                   c = '{known: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1};
            OP_I, OP_LOAD, OP_JALR: c = '{known: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
            OP_S:                   c = '{known: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
            OP_JAL:                 c = '{known: 1'b1, uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
            default:                c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pending-write vector and in-flight counter
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wb_valid, wb_rd  writeback retiring a register write
//   set_en, set_rd   issue of a writing instruction
//   pending          bit n set = write to xn in flight
//   inflight         count of outstanding writes (always popcount of pending)
//   wb_hit           this cycle's writeback retires a counted write
module hazard_scoreboard
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  reg_idx_t    wb_rd,
    input  logic        set_en,
    input  reg_idx_t    set_rd,
    output logic [31:0] pending,
    output logic [3:0]  inflight,
    output logic        wb_hit
);

    logic [31:0] after_clr;
    logic [31:0] pending_nxt;
    logic        set_hit;
    logic        set_new;
    logic [3:0]  inflight_nxt;

    always_comb begin
        wb_hit    = wb_valid && (wb_rd != '0) && pending[wb_rd];
        after_clr = pending;
        if (wb_hit) begin
            after_clr[wb_rd] = 1'b0;
        end
        set_hit     = set_en && (set_rd != '0);
        // Count only bits that actually turn on, so the counter always
        // equals the population of the vector; on a same-register
        // collision the clear and the set cancel.
        set_new     = set_hit && !after_clr[set_rd];
        pending_nxt = after_clr;
        if (set_hit) begin
            pending_nxt[set_rd] = 1'b1;
        end
        inflight_nxt = inflight + {3'b000, set_new} - {3'b000, wb_hit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            inflight <= '0;
        end else begin
            pending  <= pending_nxt;
            inflight <= inflight_nxt;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-to-EX issue and hazard controller with register scoreboard
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   dec_valid_i .. dec_rd_i    decoded instruction held in ID
//   wb_valid_i, wb_rd_i        writeback retiring a register write
//   flush_i                    kill the instruction in ID
//   stall_o, issue_o           hold ID / accept into EX (combinational)
//   pending_o, inflight_o      scoreboard state
//   stall_timeout_o            sticky flag: a stall lasted STALL_TIMEOUT cycles
module id_hazard_ctrl
    import core_pkg::*;
#(
    parameter int MAX_INFLIGHT  = 4,
    parameter int STALL_TIMEOUT = 64,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid_i,
    input  logic [6:0]  dec_opcode_i,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic [4:0]  dec_rd_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        issue_o,
    output logic [31:0] pending_o,
    output logic [3:0]  inflight_o,
    output logic        stall_timeout_o
);

    localparam logic [3:0]       MAX_CNT = 4'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(STALL_TIMEOUT);

    op_class_t  cls;
    logic [31:0] wb_onehot;
    logic [31:0] busy;
    logic        wb_hit;
    logic        src_hz;
    logic        full_hz;
    logic        hazard;
    logic        live;

    hz_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_nxt;

    assign cls = op_class(dec_opcode_i);

    // Register file writes through, so a same-cycle writeback is not busy.
    always_comb begin
        wb_onehot = '0;
        if (wb_valid_i) begin
            wb_onehot[wb_rd_i] = 1'b1;
        end
        busy = pending_o & ~wb_onehot;
    end

    assign src_hz  = (cls.uses_rs1 && (dec_rs1_i != '0) && busy[dec_rs1_i]) ||
                     (cls.uses_rs2 && (dec_rs2_i != '0) && busy[dec_rs2_i]);
    assign full_hz = cls.writes_rd && (dec_rd_i != '0) && (inflight_o == MAX_CNT) && !wb_hit;
    assign hazard  = src_hz || full_hz;

    // Nothing issues or stalls while reset is held.
    assign live    = rst_n && dec_valid_i && cls.known && !flush_i;
    assign stall_o = live && hazard;
    assign issue_o = live && !hazard;

    hazard_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid_i),
        .wb_rd    (wb_rd_i),
        .set_en   (issue_o && cls.writes_rd),
        .set_rd   (dec_rd_i),
        .pending  (pending_o),
        .inflight (inflight_o),
        .wb_hit   (wb_hit)
    );

    always_comb begin
        state_nxt   = ST_RUN;
        cnt_nxt     = '0;
        timeout_nxt = stall_timeout_o;
        if (stall_o) begin
            state_nxt = ST_STALL;
            if (state == ST_RUN) begin
                cnt_nxt = CNT_W'(1);
            end else if (cnt == '1) begin
                cnt_nxt = cnt;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
        if (cnt_nxt >= TO_CNT) begin
            timeout_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_RUN;
            cnt             <= '0;
            stall_timeout_o <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            stall_timeout_o <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - directed self-checking bench for id_hazard_ctrl
module tb_id_hazard_ctrl;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        dec_valid_i = 1'b0;
    logic [6:0]  dec_opcode_i = '0;
    logic [4:0]  dec_rs1_i = '0;
    logic [4:0]  dec_rs2_i = '0;
    logic [4:0]  dec_rd_i = '0;
    logic        wb_valid_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        issue_o;
    logic [31:0] pending_o;
    logic [3:0]  inflight_o;
    logic        stall_timeout_o;

    int checks = 0;
    int failures = 0;

    id_hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dec_valid_i     (dec_valid_i),
        .dec_opcode_i    (dec_opcode_i),
        .dec_rs1_i       (dec_rs1_i),
        .dec_rs2_i       (dec_rs2_i),
        .dec_rd_i        (dec_rd_i),
        .wb_valid_i      (wb_valid_i),
        .wb_rd_i         (wb_rd_i),
        .flush_i         (flush_i),
        .stall_o         (stall_o),
        .issue_o         (issue_o),
        .pending_o       (pending_o),
        .inflight_o      (inflight_o),
        .stall_timeout_o (stall_timeout_o)
    );

    always #5 clk = ~clk;

    // Advance one cycle, then confirm the counter still matches the vector.
    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if (inflight_o !== 4'($countones(pending_o))) begin
            failures++;
            $display("FAIL invariant: inflight_o=%0d popcount=%0d", inflight_o, $countones(pending_o));
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        dec_valid_i  = v;
        dec_opcode_i = op;
        dec_rd_i     = rd;
        dec_rs1_i    = rs1;
        dec_rs2_i    = rs2;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd);
        wb_valid_i = v;
        wb_rd_i    = rd;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        wb(1'b0, 5'd0);
        flush_i = 1'b0;
    endtask

    task automatic chk_ctl(input string name, input logic exp_stall, input logic exp_issue);
        @(negedge clk);
        checks++;
        if (stall_o !== exp_stall || issue_o !== exp_issue) begin
            failures++;
            $display("FAIL %s: stall_o=%b issue_o=%b expected stall_o=%b issue_o=%b",
                     name, stall_o, issue_o, exp_stall, exp_issue);
        end
    endtask

    task automatic chk_sb(input string name, input logic [31:0] exp_p, input logic [3:0] exp_n);
        checks++;
        if (pending_o !== exp_p || inflight_o !== exp_n) begin
            failures++;
            $display("FAIL %s: pending_o=%h inflight_o=%0d expected pending_o=%h inflight_o=%0d",
                     name, pending_o, inflight_o, exp_p, exp_n);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        chk_sb("reset_sb", 32'h0, 4'd0);
        checks++;
        if (stall_o !== 1'b0 || issue_o !== 1'b0 || stall_timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: stall=%b issue=%b timeout=%b expected 0 0 0",
                     stall_o, issue_o, stall_timeout_o);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_raw();
        drive(1'b1, OP_R, 5'd5, 5'd1, 5'd2);
        chk_ctl("raw_add_x5", 1'b0, 1'b1);
        tick();
        drive(1'b1, OP_R, 5'd6, 5'd5, 5'd3);
        chk_ctl("raw_dep_stall", 1'b1, 1'b0);
        chk_sb("raw_pending_x5", 32'h0000_0020, 4'd1);
        tick();
        wb(1'b1, 5'd5);
        chk_ctl("raw_wb_issue", 1'b0, 1'b1);
        tick();
        idle();
        chk_sb("raw_pending_x6", 32'h0000_0040, 4'd1);
        wb(1'b1, 5'd6);
        tick();
        idle();
        chk_sb("raw_drain", 32'h0, 4'd0);
    endtask

    task automatic test_x0();
        drive(1'b1, OP_LOAD, 5'd0, 5'd1, 5'd0);
        chk_ctl("x0_lw", 1'b0, 1'b1);
        tick();
        chk_sb("x0_lw_no_pending", 32'h0, 4'd0);
        drive(1'b1, OP_R, 5'd7, 5'd0, 5'd0);
        chk_ctl("x0_add_no_stall", 1'b0, 1'b1);
        chk_sb("x0_still_zero", 32'h0, 4'd0);
        tick();
        idle();
        wb(1'b1, 5'd7);
        tick();
        idle();
        chk_sb("x0_drain", 32'h0, 4'd0);
    endtask

    task automatic test_full();
        for (int r = 1; r <= 4; r++) begin
            drive(1'b1, OP_I, 5'(r), 5'd0, 5'd0);
            tick();
        end
        idle();
        chk_sb("full_four", 32'h0000_001E, 4'd4);
        drive(1'b1, OP_I, 5'd8, 5'd0, 5'd0);
        chk_ctl("full_fifth_stall", 1'b1, 1'b0);
        tick();
        wb(1'b1, 5'd1);
        chk_ctl("full_wb_issue", 1'b0, 1'b1);
        tick();
        idle();
        chk_sb("full_after", 32'h0000_011C, 4'd4);
        for (int r = 2; r <= 4; r++) begin
            wb(1'b1, 5'(r));
            tick();
        end
        wb(1'b1, 5'd8);
        tick();
        idle();
        chk_sb("full_drain", 32'h0, 4'd0);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, OP_I, 5'd9, 5'd0, 5'd0);
        tick();
        drive(1'b1, OP_I, 5'd9, 5'd0, 5'd0);
        wb(1'b1, 5'd9);
        chk_ctl("collide_issue", 1'b0, 1'b1);
        tick();
        idle();
        chk_sb("collide_bit_kept", 32'h0000_0200, 4'd1);
        wb(1'b1, 5'd12);
        tick();
        idle();
        chk_sb("wb_unpending", 32'h0000_0200, 4'd1);
        wb(1'b1, 5'd9);
        tick();
        idle();
        chk_sb("collide_drain", 32'h0, 4'd0);
    endtask

    task automatic test_timeout();
        drive(1'b1, OP_R, 5'd5, 5'd0, 5'd0);
        tick();
        drive(1'b1, OP_R, 5'd6, 5'd5, 5'd0);
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 63) begin
                checks++;
                if (stall_timeout_o !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_early: stall_timeout_o=%b expected 0 at cycle 63", stall_timeout_o);
                end
            end
        end
        checks++;
        if (stall_timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set: stall_timeout_o=%b expected 1 at cycle 64", stall_timeout_o);
        end
        wb(1'b1, 5'd5);
        chk_ctl("timeout_release", 1'b0, 1'b1);
        tick();
        idle();
        tick();
        checks++;
        if (stall_timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: stall_timeout_o=%b expected 1", stall_timeout_o);
        end
        drive(1'b1, OP_R, 5'd7, 5'd6, 5'd0);
        chk_ctl("rst_mid_stall_pre", 1'b1, 1'b0);
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_sb("rst_mid_sb", 32'h0, 4'd0);
        checks++;
        if (stall_o !== 1'b0 || issue_o !== 1'b0 || stall_timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_ctl: stall=%b issue=%b timeout=%b expected 0 0 0",
                     stall_o, issue_o, stall_timeout_o);
        end
        idle();
        tick();
        rst_n = 1'b1;
        wb(1'b1, 5'd6);
        tick();
        idle();
        chk_sb("rst_stale_wb_ignored", 32'h0, 4'd0);
    endtask

    task automatic test_flush();
        drive(1'b1, OP_R, 5'd5, 5'd0, 5'd0);
        tick();
        drive(1'b1, OP_S, 5'd0, 5'd5, 5'd5);
        chk_ctl("flush_sw_stall", 1'b1, 1'b0);
        tick();
        flush_i = 1'b1;
        chk_ctl("flush_wins", 1'b0, 1'b0);
        tick();
        checks++;
        if (dut.state !== ST_RUN) begin
            failures++;
            $display("FAIL flush_fsm: state=%0d expected RUN", dut.state);
        end
        chk_sb("flush_pending_kept", 32'h0000_0020, 4'd1);
        flush_i = 1'b0;
        drive(1'b1, 7'h7F, 5'd3, 5'd5, 5'd5);
        chk_ctl("unknown_op", 1'b0, 1'b0);
        tick();
        idle();
        chk_sb("unknown_no_write", 32'h0000_0020, 4'd1);
        wb(1'b1, 5'd5);
        tick();
        idle();
        chk_sb("flush_drain", 32'h0, 4'd0);
    endtask

    initial begin
        test_reset();
        test_raw();
        test_x0();
        test_full();
        test_back_to_back();
        test_timeout();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
